// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits of a WIDTH-bit add per clock,
// rippling the carry through a flop, with start/ready and valid/ready handshakes.
module seq_chunk_adder #(
   parameter int WIDTH = 24,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic [1:0]       kIn,
   output logic [WIDTH:0]   sum,
   output logic [1:0]       kOut,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic             carry_reg, carry_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH:0]   sum_reg, sum_next;
   logic [1:0]       kout_reg, kout_next;
   logic             valid_reg, valid_next;

   logic [CHUNK-1:0] a_sel, b_sel;
   logic [CHUNK:0]   chunk_sum;

   // Mux out the operand slice addressed by the chunk counter.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (cnt_reg == CW'(i)) begin
            a_sel = a_reg[i*CHUNK +: CHUNK];
            b_sel = b_reg[i*CHUNK +: CHUNK];
         end
      end
   end

   assign chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry_reg};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         cnt_reg   <= '0;
         sum_reg   <= '0;
         kout_reg  <= 2'b00;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         carry_reg <= carry_next;
         cnt_reg   <= cnt_next;
         sum_reg   <= sum_next;
         kout_reg  <= kout_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      carry_next = carry_reg;
      cnt_next   = cnt_reg;
      sum_next   = sum_reg;
      kout_next  = kout_reg;
      valid_next = valid_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next     = a;
               // Subtraction is A + ~B + 1; the forced carry-in overrides kIn.
               b_next     = sub ? ~b : b;
               carry_next = sub | (kIn == 2'b11);
               cnt_next   = '0;
               state_next = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NCHUNK; i++) begin
               if (cnt_reg == CW'(i)) sum_next[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            end
            carry_next = chunk_sum[CHUNK];
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == CW'(NCHUNK - 1)) begin
               sum_next[WIDTH] = chunk_sum[CHUNK];
               kout_next       = {2{chunk_sum[CHUNK]}};
               valid_next      = 1'b1;
               state_next      = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign in_ready  = (state_reg == IDLE);
   assign sum       = sum_reg;
   assign kOut      = kout_reg;
   assign out_valid = valid_reg;

endmodule
